// File: rtl/handshake_pkg.sv
// Shared constants and helpers for the handshake demux buffer.
// Optional macro: HANDSHAKE_DEMUX_BUF_ERR_CNT_EN (enables the err_cnt counter in the top).
package handshake_pkg;

    localparam int unsigned ERR_CNT_WIDTH = 16;

    // Select width; a single output still gets a 1-bit select.
    function automatic int unsigned sel_width(input int unsigned n);
        return (n > 1) ? int'($clog2(n)) : 1;
    endfunction

endpackage

// File: rtl/handshake_reg_slice.sv
// One-entry valid/ready register slot. Accepts a new token in the same cycle the held
// token drains, so a continuously ready consumer sees one token per cycle.
// Optional macro: HANDSHAKE_DEMUX_BUF_ERR_CNT_EN (not used in this file).
module handshake_reg_slice #(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data
);

    logic             full_q;
    logic             full_d;
    logic             load;
    logic [WIDTH-1:0] data_q;

    // Slot is free when empty or draining this cycle; load wins over drain.
    always_comb begin
        in_ready = !full_q || out_ready;
        load     = in_valid && in_ready;
        full_d   = full_q;
        if (load) begin
            full_d = 1'b1;
        end else if (out_ready) begin
            full_d = 1'b0;
        end
    end

    // Occupancy flag, cleared asynchronously so out_valid drops at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            full_q <= 1'b0;
        end else begin
            full_q <= full_d;
        end
    end

    // Payload needs no reset; it holds the last loaded value while empty.
    always_ff @(posedge clk) begin
        if (load) begin
            data_q <= in_data;
        end
    end

    assign out_valid = full_q;
    assign out_data  = data_q;

endmodule

// File: rtl/handshake_demux_buf.sv
// Demultiplexes a data stream to NUM_OUTPUTS buffered outputs under control of a
// paired select stream. Out-of-range selects are consumed, dropped and flagged.
// Optional macro: HANDSHAKE_DEMUX_BUF_ERR_CNT_EN adds the saturating err_cnt output.
module handshake_demux_buf
    import handshake_pkg::*;
#(
    parameter int unsigned  NUM_OUTPUTS = 2,
    parameter int unsigned  WIDTH       = 32,
    localparam int unsigned SEL_WIDTH   = sel_width(NUM_OUTPUTS)
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         sel_valid,
    output logic                         sel_ready,
    input  logic [SEL_WIDTH-1:0]         sel_data,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic [NUM_OUTPUTS-1:0]       out_valid,
    input  logic [NUM_OUTPUTS-1:0]       out_ready,
    output logic [NUM_OUTPUTS*WIDTH-1:0] out_data,
`ifdef HANDSHAKE_DEMUX_BUF_ERR_CNT_EN
    output logic [ERR_CNT_WIDTH-1:0]     err_cnt,
`endif
    output logic                         err_oob
);

    logic [NUM_OUTPUTS-1:0] slot_free;
    logic [NUM_OUTPUTS-1:0] slot_load;
    logic                   sel_oob;
    logic                   target_free;
    logic                   fire;
    logic                   oob_fire;
    logic                   err_oob_q;

    // Both tokens fire together when the target slot can take data or the select is
    // out of range (which is always accepted and dropped). Nothing fires in reset.
    always_comb begin
        sel_oob     = 32'(sel_data) >= NUM_OUTPUTS;
        target_free = 1'b0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            if (32'(sel_data) == i) begin
                target_free = slot_free[i];
            end
        end
        fire     = rst_n && sel_valid && in_valid && (sel_oob || target_free);
        oob_fire = fire && sel_oob;
        slot_load = '0;
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            slot_load[i] = fire && !sel_oob && (32'(sel_data) == i);
        end
    end

    assign sel_ready = fire;
    assign in_ready  = fire;

    for (genvar g = 0; g < NUM_OUTPUTS; g++) begin : g_slot
        handshake_reg_slice #(
            .WIDTH(WIDTH)
        ) u_slice (
            .clk      (clk),
            .rst_n    (rst_n),
            .in_valid (slot_load[g]),
            .in_ready (slot_free[g]),
            .in_data  (in_data),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .out_data (out_data[g*WIDTH +: WIDTH])
        );
    end

    // Sticky out-of-range flag, held until reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_oob_q <= 1'b0;
        end else if (oob_fire) begin
            err_oob_q <= 1'b1;
        end
    end

    assign err_oob = err_oob_q;

`ifdef HANDSHAKE_DEMUX_BUF_ERR_CNT_EN
    logic [ERR_CNT_WIDTH-1:0] err_cnt_q;

    // Saturating count of out-of-range events.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_cnt_q <= '0;
        end else if (oob_fire && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + 1'b1;
        end
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_handshake_demux_buf.sv
// Self-checking bench for handshake_demux_buf with five outputs so that selects 5..7
// exercise the out-of-range path. Optional macro: HANDSHAKE_DEMUX_BUF_ERR_CNT_EN.
module tb_handshake_demux_buf;

    localparam int unsigned N  = 5;
    localparam int unsigned W  = 32;
    localparam int unsigned SW = 3;

    logic          clk       = 1'b0;
    logic          rst_n     = 1'b0;
    logic          sel_valid = 1'b0;
    logic          in_valid  = 1'b0;
    logic [SW-1:0] sel_data  = '0;
    logic [W-1:0]  in_data   = '0;
    logic [N-1:0]  out_ready = '1;

    wire           sel_ready;
    wire           in_ready;
    wire [N-1:0]   out_valid;
    wire [N*W-1:0] out_data;
    wire           err_oob;
`ifdef HANDSHAKE_DEMUX_BUF_ERR_CNT_EN
    wire [15:0]    err_cnt;
`endif

    handshake_demux_buf #(
        .NUM_OUTPUTS(N),
        .WIDTH      (W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_valid(sel_valid),
        .sel_ready(sel_ready),
        .sel_data (sel_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_data (out_data),
`ifdef HANDSHAKE_DEMUX_BUF_ERR_CNT_EN
        .err_cnt  (err_cnt),
`endif
        .err_oob  (err_oob)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Model: each output is a queue holding at most one token; plus error state.
    logic [W-1:0] mq[N][$];
    logic         m_err = 1'b0;
    logic [15:0]  m_cnt = '0;

    logic [N-1:0] e_v;
    logic         e_fire;
    logic         e_oob;
    logic         e_free;
    int           t;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model mid-cycle, then advance the model with the inputs
    // that the next rising edge will sample.
    always @(negedge clk) begin
        if (!rst_n) begin
            chk("rst_out_valid", 32'(out_valid), 32'd0);
            chk("rst_sel_ready", 32'(sel_ready), 32'd0);
            chk("rst_in_ready", 32'(in_ready), 32'd0);
            chk("rst_err_oob", 32'(err_oob), 32'd0);
            for (int i = 0; i < N; i++) mq[i].delete();
            m_err = 1'b0;
            m_cnt = '0;
        end else begin
            for (int i = 0; i < N; i++) e_v[i] = (mq[i].size() != 0);
            chk("out_valid", 32'(out_valid), 32'(e_v));
            for (int i = 0; i < N; i++) begin
                if (mq[i].size() != 0) chk($sformatf("out_data[%0d]", i), out_data[i*W +: W], mq[i][0]);
            end
            t      = int'(sel_data);
            e_oob  = (t >= N);
            e_free = 1'b0;
            if (!e_oob) e_free = (mq[t].size() == 0) || out_ready[t];
            e_fire = sel_valid && in_valid && (e_oob || e_free);
            chk("sel_ready", 32'(sel_ready), 32'(e_fire));
            chk("in_ready", 32'(in_ready), 32'(e_fire));
            chk("err_oob", 32'(err_oob), 32'(m_err));
`ifdef HANDSHAKE_DEMUX_BUF_ERR_CNT_EN
            chk("err_cnt", 32'(err_cnt), 32'(m_cnt));
`endif
            for (int i = 0; i < N; i++) begin
                if ((mq[i].size() != 0) && out_ready[i]) void'(mq[i].pop_front());
            end
            if (e_fire) begin
                if (e_oob) begin
                    m_err = 1'b1;
                    if (m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
                end else begin
                    mq[t].push_back(in_data);
                end
            end
        end
    end

    task automatic drive(input logic v, input logic [SW-1:0] s, input logic [W-1:0] d,
                         input logic [N-1:0] r);
        @(posedge clk);
        #1;
        sel_valid = v;
        in_valid  = v;
        sel_data  = s;
        in_data   = d;
        out_ready = r;
    endtask

    int n_acc;
    int n_out;

    initial begin
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Single token to output 2, one-cycle latency.
        drive(1'b1, 3'd2, 32'hA5A5_0001, '1);
        @(negedge clk);
        chk("t1_sel_ready", 32'(sel_ready), 32'd1);
        chk("t1_in_ready", 32'(in_ready), 32'd1);
        chk("t1_err_oob_clear", 32'(err_oob), 32'd0);
        drive(1'b0, 3'd0, 32'h0, '1);
        @(negedge clk);
        chk("t1_out_valid", 32'(out_valid), 32'h04);
        chk("t1_out_data", out_data[2*W +: W], 32'hA5A5_0001);

        // Output 1 stalled: first token buffered, token to 3 passes, second token waits.
        drive(1'b1, 3'd1, 32'hB000_0001, 5'b11101);
        @(negedge clk);
        chk("t2_first_accept", 32'(in_ready), 32'd1);
        drive(1'b1, 3'd3, 32'hC000_0003, 5'b11101);
        @(negedge clk);
        chk("t3_accept", 32'(in_ready), 32'd1);
        drive(1'b1, 3'd1, 32'hB000_0002, 5'b11101);
        @(negedge clk);
        chk("t3_out_valid", 32'(out_valid), 32'h0A);
        chk("t3_out3_data", out_data[3*W +: W], 32'hC000_0003);
        chk("t2_stall", 32'(in_ready), 32'd0);
        repeat (2) begin
            drive(1'b1, 3'd1, 32'hB000_0002, 5'b11101);
            @(negedge clk);
            chk("t2_stall_hold", 32'(in_ready), 32'd0);
            chk("t2_held_data", out_data[1*W +: W], 32'hB000_0001);
        end
        drive(1'b1, 3'd1, 32'hB000_0002, '1);
        @(negedge clk);
        chk("t2_release", 32'(in_ready), 32'd1);
        chk("t2_first_out", out_data[1*W +: W], 32'hB000_0001);
        drive(1'b0, 3'd0, 32'h0, '1);
        @(negedge clk);
        chk("t2_second_valid", 32'(out_valid), 32'h02);
        chk("t2_second_out", out_data[1*W +: W], 32'hB000_0002);

        // Ten back-to-back tokens to output 0 over eleven cycles.
        n_acc = 0;
        n_out = 0;
        for (int k = 0; k < 11; k++) begin
            if (k < 10) drive(1'b1, 3'd0, 32'hD000_0000 + 32'(k), '1);
            else        drive(1'b0, 3'd0, 32'h0, '1);
            @(negedge clk);
            if (in_ready) n_acc++;
            if (out_valid[0]) n_out++;
        end
        chk("t4_accepted", 32'(n_acc), 32'd10);
        chk("t4_emitted", 32'(n_out), 32'd10);

        // Out-of-range selects are consumed and flagged.
        for (int k = 5; k < 8; k++) begin
            drive(1'b1, SW'(k), 32'hE000_0000, '1);
            @(negedge clk);
            chk("t5_consumed", 32'(sel_ready), 32'd1);
        end
        drive(1'b0, 3'd0, 32'h0, '1);
        @(negedge clk);
        chk("t5_no_valid", 32'(out_valid), 32'd0);
        chk("t5_err_oob", 32'(err_oob), 32'd1);
`ifdef HANDSHAKE_DEMUX_BUF_ERR_CNT_EN
        chk("t5_err_cnt", 32'(err_cnt), 32'd3);
`endif

        // Reset with slots 0 and 2 full.
        drive(1'b1, 3'd0, 32'hF000_0000, '0);
        drive(1'b1, 3'd2, 32'hF000_0002, '0);
        drive(1'b0, 3'd0, 32'h0, '0);
        @(negedge clk);
        chk("t6_full_before", 32'(out_valid), 32'h05);
        @(posedge clk);
        #1;
        sel_valid = 1'b1;
        in_valid  = 1'b1;
        sel_data  = 3'd1;
        rst_n     = 1'b0;
        #1;
        chk("t6_valid_cleared", 32'(out_valid), 32'd0);
        chk("t6_err_cleared", 32'(err_oob), 32'd0);
        chk("t6_no_ready", 32'(sel_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n     = 1'b1;
        sel_valid = 1'b0;
        in_valid  = 1'b0;
        out_ready = '1;
        repeat (3) begin
            @(negedge clk);
            chk("t6_nothing_emitted", 32'(out_valid), 32'd0);
        end

        // Random traffic against the model, with occasional resets.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            rst_n     = ($urandom_range(299) != 0);
            sel_valid = ($urandom_range(3) != 0);
            in_valid  = ($urandom_range(3) != 0);
            if ($urandom_range(15) == 0) sel_data = SW'($urandom_range(7, 5));
            else                         sel_data = SW'($urandom_range(4));
            in_data   = $urandom;
            out_ready = N'($urandom);
        end
        drive(1'b0, 3'd0, 32'h0, '1);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
